// File: rtl/rv64i_control_unit_pkg.sv
// Shared definitions for the RV64I multicycle control unit: opcodes, FSM states,
// write-back source codes, store byte masks and the decoded selector bundle.
package rv64i_control_unit_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [7:0] MASK_BYTE   = 8'h01;
    localparam logic [7:0] MASK_HALF   = 8'h03;
    localparam logic [7:0] MASK_WORD   = 8'h0F;
    localparam logic [7:0] MASK_DOUBLE = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FETCH_WAIT,
        ST_EXECUTE,
        ST_MEM_WAIT,
        ST_WRITEBACK
    } state_t;

    typedef enum logic [1:0] {
        WR_SRC_ALU = 2'b00,
        WR_SRC_MEM = 2'b01,
        WR_SRC_PC4 = 2'b10,
        WR_SRC_IMM = 2'b11
    } wr_src_t;

    typedef struct packed {
        logic       alua_src;
        logic       alub_src;
        logic       aluy_src;
        logic [2:0] alu_src;
        logic       carry_in;
        logic       arithmetic;
        logic       alupc_src;
        logic       pc_src;
        logic [2:0] read_data_src;
        wr_src_t    write_register_src;
    } ctrl_t;

endpackage

// File: rtl/rv64i_control_unit_decoder.sv
// Combinational instruction decoder: maps opcode/funct fields and ALU flags to
// datapath selectors, branch decision and store byte mask.
module control_decoder
    import rv64i_control_unit_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       negative,
    input  logic       carry_out,
    input  logic       overflow,
    output ctrl_t      ctrl,
    output logic [7:0] byte_mask,
    output logic       is_load,
    output logic       is_store,
    output logic       reg_write
);

    logic branch_taken;
    logic unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        case (funct3)
            F3_BEQ:  branch_taken = zero;
            F3_BNE:  branch_taken = !zero;
            F3_BLT:  branch_taken = negative ^ overflow;
            F3_BGE:  branch_taken = !(negative ^ overflow);
            F3_BLTU: branch_taken = !carry_out;
            F3_BGEU: branch_taken = carry_out;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        ctrl      = '0;
        byte_mask = '0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        reg_write = 1'b0;
        case (opcode)
            OPC_OP, OPC_OP_32: begin
                ctrl.alu_src    = funct3;
                ctrl.arithmetic = funct7[5];
                // Comparisons reuse the subtractor, so they need the +1 carry too.
                ctrl.carry_in   = ((funct3 == F3_ADD_SUB) && funct7[5]) ||
                                  (funct3 == F3_SLT) || (funct3 == F3_SLTU);
                ctrl.aluy_src   = (opcode == OPC_OP_32);
                reg_write       = 1'b1;
            end
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                ctrl.alub_src   = 1'b1;
                ctrl.alu_src    = funct3;
                ctrl.arithmetic = (funct3 == F3_SRL_SRA) && funct7[5];
                ctrl.carry_in   = (funct3 == F3_SLT) || (funct3 == F3_SLTU);
                ctrl.aluy_src   = (opcode == OPC_OP_IMM_32);
                reg_write       = 1'b1;
            end
            OPC_LUI: begin
                ctrl.write_register_src = WR_SRC_IMM;
                reg_write               = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl.alua_src = 1'b1;
                ctrl.alub_src = 1'b1;
                reg_write     = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                ctrl.pc_src             = 1'b1;
                ctrl.alupc_src          = (opcode == OPC_JALR);
                ctrl.write_register_src = WR_SRC_PC4;
                reg_write               = 1'b1;
            end
            OPC_LOAD: begin
                ctrl.alub_src           = 1'b1;
                ctrl.write_register_src = WR_SRC_MEM;
                ctrl.read_data_src      = funct3;
                is_load                 = 1'b1;
                reg_write               = 1'b1;
            end
            OPC_STORE: begin
                ctrl.alub_src = 1'b1;
                is_store      = 1'b1;
                case (funct3[1:0])
                    2'b00:   byte_mask = MASK_BYTE;
                    2'b01:   byte_mask = MASK_HALF;
                    2'b10:   byte_mask = MASK_WORD;
                    default: byte_mask = MASK_DOUBLE;
                endcase
            end
            OPC_BRANCH: begin
                ctrl.arithmetic = 1'b1;
                ctrl.carry_in   = 1'b1;
                ctrl.pc_src     = branch_taken;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv64i_control_unit.sv
// Multicycle FSM for the RV64I core: sequences fetch, execute and data-memory
// access, gating the decoder outputs and the single-cycle PC/register strobes.
module rv64i_control_unit
    import rv64i_control_unit_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    output logic       instruction_mem_enable,
    input  logic       instruction_mem_busy,
    output logic       data_mem_enable,
    output logic [7:0] data_mem_byte_write_enable,
    input  logic       data_mem_busy,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       negative,
    input  logic       carry_out,
    input  logic       overflow,
    output logic       alua_src,
    output logic       alub_src,
    output logic       aluy_src,
    output logic [2:0] alu_src,
    output logic       carry_in,
    output logic       arithmetic,
    output logic       alupc_src,
    output logic       pc_src,
    output logic       pc_enable,
    output logic [2:0] read_data_src,
    output logic [1:0] write_register_src,
    output logic       write_register_enable
);

    state_t     state;
    state_t     next_state;
    ctrl_t      ctrl;
    logic [7:0] byte_mask;
    logic       is_load;
    logic       is_store;
    logic       reg_write;
    logic       sel_active;

    control_decoder u_decoder (
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .zero      (zero),
        .negative  (negative),
        .carry_out (carry_out),
        .overflow  (overflow),
        .ctrl      (ctrl),
        .byte_mask (byte_mask),
        .is_load   (is_load),
        .is_store  (is_store),
        .reg_write (reg_write)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    assign sel_active = (state == ST_EXECUTE) || (state == ST_MEM_WAIT) ||
                        (state == ST_WRITEBACK);

    always_comb begin
        next_state                 = state;
        instruction_mem_enable     = 1'b0;
        data_mem_enable            = 1'b0;
        data_mem_byte_write_enable = '0;
        pc_enable                  = 1'b0;
        write_register_enable      = 1'b0;
        alua_src                   = 1'b0;
        alub_src                   = 1'b0;
        aluy_src                   = 1'b0;
        alu_src                    = '0;
        carry_in                   = 1'b0;
        arithmetic                 = 1'b0;
        alupc_src                  = 1'b0;
        pc_src                     = 1'b0;
        read_data_src              = '0;
        write_register_src         = '0;

        // Fields are held stable by the datapath until retirement, so the decode
        // stays valid through MEM_WAIT and WRITEBACK without a local copy.
        if (sel_active) begin
            alua_src           = ctrl.alua_src;
            alub_src           = ctrl.alub_src;
            aluy_src           = ctrl.aluy_src;
            alu_src            = ctrl.alu_src;
            carry_in           = ctrl.carry_in;
            arithmetic         = ctrl.arithmetic;
            alupc_src          = ctrl.alupc_src;
            pc_src             = ctrl.pc_src;
            read_data_src      = ctrl.read_data_src;
            write_register_src = ctrl.write_register_src;
        end

        case (state)
            ST_IDLE: next_state = ST_FETCH;
            ST_FETCH: begin
                instruction_mem_enable = 1'b1;
                next_state             = ST_FETCH_WAIT;
            end
            ST_FETCH_WAIT: begin
                if (!instruction_mem_busy) next_state = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (is_load || is_store) begin
                    data_mem_enable            = 1'b1;
                    data_mem_byte_write_enable = byte_mask;
                    next_state                 = ST_MEM_WAIT;
                end else begin
                    pc_enable             = 1'b1;
                    write_register_enable = reg_write;
                    next_state            = ST_FETCH;
                end
            end
            ST_MEM_WAIT: begin
                if (!data_mem_busy) next_state = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                pc_enable             = 1'b1;
                write_register_enable = is_load;
                next_state            = ST_FETCH;
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rv64i_control_unit.sv
// Randomized self-checking bench for rv64i_control_unit against a behavioural
// model of the per-instruction selector values and strobe timing.
module tb_rv64i_control_unit;

    logic       clock;
    logic       reset;
    logic       instruction_mem_enable;
    logic       instruction_mem_busy;
    logic       data_mem_enable;
    logic [7:0] data_mem_byte_write_enable;
    logic       data_mem_busy;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero, negative, carry_out, overflow;
    logic       alua_src, alub_src, aluy_src;
    logic [2:0] alu_src;
    logic       carry_in, arithmetic, alupc_src, pc_src, pc_enable;
    logic [2:0] read_data_src;
    logic [1:0] write_register_src;
    logic       write_register_enable;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit       alua, alub, aluy;
        bit [2:0] alu;
        bit       cin, arith, alupc, pcs;
        bit [2:0] rds;
        bit [1:0] wrs;
        bit [7:0] mask;
        bit       mem, load, wr;
    } exp_t;

    rv64i_control_unit dut (
        .clock                      (clock),
        .reset                      (reset),
        .instruction_mem_enable     (instruction_mem_enable),
        .instruction_mem_busy       (instruction_mem_busy),
        .data_mem_enable            (data_mem_enable),
        .data_mem_byte_write_enable (data_mem_byte_write_enable),
        .data_mem_busy              (data_mem_busy),
        .opcode                     (opcode),
        .funct3                     (funct3),
        .funct7                     (funct7),
        .zero                       (zero),
        .negative                   (negative),
        .carry_out                  (carry_out),
        .overflow                   (overflow),
        .alua_src                   (alua_src),
        .alub_src                   (alub_src),
        .aluy_src                   (aluy_src),
        .alu_src                    (alu_src),
        .carry_in                   (carry_in),
        .arithmetic                 (arithmetic),
        .alupc_src                  (alupc_src),
        .pc_src                     (pc_src),
        .pc_enable                  (pc_enable),
        .read_data_src              (read_data_src),
        .write_register_src         (write_register_src),
        .write_register_enable      (write_register_enable)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input bit [6:0] op, input bit [2:0] f3, input bit [6:0] f7,
                                   input bit z, input bit n, input bit c, input bit v);
        exp_t e;
        bit       lt;
        bit [7:0] taken;
        e = '{default: 0};
        lt = n ^ v;
        taken = {c, !c, !lt, lt, 1'b0, 1'b0, !z, z};
        if (op == 7'h33 || op == 7'h3b || op == 7'h13 || op == 7'h1b) begin
            e.alub  = (op == 7'h13 || op == 7'h1b);
            e.aluy  = (op == 7'h3b || op == 7'h1b);
            e.alu   = f3;
            e.arith = e.alub ? (f3 == 3'd5 && f7[5]) : f7[5];
            e.cin   = (f3 == 3'd2) || (f3 == 3'd3) || (!e.alub && f3 == 3'd0 && f7[5]);
            e.wr    = 1;
        end else if (op == 7'h37) begin
            e.wrs = 2'd3; e.wr = 1;
        end else if (op == 7'h17) begin
            e.alua = 1; e.alub = 1; e.wr = 1;
        end else if (op == 7'h6f || op == 7'h67) begin
            e.pcs = 1; e.alupc = (op == 7'h67); e.wrs = 2'd2; e.wr = 1;
        end else if (op == 7'h03) begin
            e.alub = 1; e.mem = 1; e.load = 1; e.wrs = 2'd1; e.rds = f3; e.wr = 1;
        end else if (op == 7'h23) begin
            e.alub = 1; e.mem = 1;
            e.mask = 8'((1 << (1 << f3[1:0])) - 1);
        end else if (op == 7'h63) begin
            e.arith = 1; e.cin = 1; e.pcs = taken[f3];
        end
        return e;
    endfunction

    task automatic check_sel(input string where, input exp_t e);
        check({where, ".alua_src"}, alua_src, e.alua);
        check({where, ".alub_src"}, alub_src, e.alub);
        check({where, ".aluy_src"}, aluy_src, e.aluy);
        check({where, ".alu_src"}, alu_src, e.alu);
        check({where, ".carry_in"}, carry_in, e.cin);
        check({where, ".arithmetic"}, arithmetic, e.arith);
        check({where, ".alupc_src"}, alupc_src, e.alupc);
        check({where, ".pc_src"}, pc_src, e.pcs);
        check({where, ".read_data_src"}, read_data_src, e.rds);
        check({where, ".write_register_src"}, write_register_src, e.wrs);
    endtask

    function automatic logic [31:0] all_outputs();
        return {instruction_mem_enable, data_mem_enable, data_mem_byte_write_enable,
                alua_src, alub_src, aluy_src, alu_src, carry_in, arithmetic, alupc_src,
                pc_src, pc_enable, read_data_src, write_register_src, write_register_enable};
    endfunction

    // abort_at > 0 pulls reset low in that MEM_WAIT cycle of a memory instruction.
    task automatic run_instr(input bit [6:0] op, input bit [2:0] f3, input bit [6:0] f7,
                             input bit z, input bit n, input bit c, input bit v,
                             input int kf, input int km, input int abort_at);
        exp_t e;
        int   cnt;
        opcode = op; funct3 = f3; funct7 = f7;
        zero = z; negative = n; carry_out = c; overflow = v;
        e = model(op, f3, f7, z, n, c, v);
        cnt = 0;
        while (instruction_mem_enable !== 1'b1 && cnt < 12) begin
            @(negedge clock);
            cnt++;
        end
        check("fetch_seen", instruction_mem_enable, 1'b1);
        if (instruction_mem_enable !== 1'b1) return;
        check("fetch_quiet", {pc_enable, write_register_enable, data_mem_enable, pc_src}, 4'b0);
        for (int i = 1; i <= kf + 1; i++) begin
            @(negedge clock);
            check("fwait_imem_en", instruction_mem_enable, 1'b0);
            check("fwait_strobes", {pc_enable, write_register_enable, data_mem_enable}, 3'b0);
            instruction_mem_busy = (i <= kf);
        end
        @(negedge clock);
        check("exec_imem_en", instruction_mem_enable, 1'b0);
        check_sel("exec", e);
        check("exec_dmem_en", data_mem_enable, e.mem);
        check("exec_mask", data_mem_byte_write_enable, e.mask);
        check("exec_pc_en", pc_enable, !e.mem);
        check("exec_wr_en", write_register_enable, !e.mem && e.wr);
        if (e.mem) begin
            for (int i = 1; i <= km + 1; i++) begin
                @(negedge clock);
                if (i == abort_at) begin
                    reset = 1'b0;
                    #1;
                    check("abort_outputs", all_outputs(), 32'd0);
                    repeat (2) begin
                        @(negedge clock);
                        check("abort_held", all_outputs(), 32'd0);
                    end
                    reset = 1'b1;
                    data_mem_busy = 1'b0;
                    #1;
                    check("abort_idle", instruction_mem_enable, 1'b0);
                    return;
                end
                check("mwait_strobes", {data_mem_enable, pc_enable, write_register_enable}, 3'b0);
                check("mwait_mask", data_mem_byte_write_enable, 8'h00);
                check_sel("mwait", e);
                data_mem_busy = (i <= km);
            end
            @(negedge clock);
            check("wb_pc_en", pc_enable, 1'b1);
            check("wb_wr_en", write_register_enable, e.load);
            check("wb_dmem_en", data_mem_enable, 1'b0);
            check_sel("wb", e);
        end
        @(negedge clock);
        check("next_fetch", instruction_mem_enable, 1'b1);
        check("strobe_single", {pc_enable, write_register_enable}, 2'b0);
    endtask

    bit [6:0] valid_ops [11] = '{7'h33, 7'h3b, 7'h13, 7'h1b, 7'h37, 7'h17,
                                 7'h6f, 7'h67, 7'h03, 7'h23, 7'h63};

    initial begin
        bit [6:0] op, f7;
        bit [3:0] fl;
        reset = 1'b0;
        instruction_mem_busy = 1'b0;
        data_mem_busy = 1'b0;
        opcode = '0; funct3 = '0; funct7 = '0;
        zero = 0; negative = 0; carry_out = 0; overflow = 0;
        #1;
        check("reset_outputs", all_outputs(), 32'd0);
        repeat (3) begin
            @(negedge clock);
            check("reset_outputs", all_outputs(), 32'd0);
        end
        reset = 1'b1;
        #1;
        check("idle_after_release", instruction_mem_enable, 1'b0);
        @(negedge clock);
        check("first_fetch", instruction_mem_enable, 1'b1);

        run_instr(7'h33, 3'd0, 7'h00, 0, 0, 0, 0, 2, 0, 0);   // ADD
        run_instr(7'h33, 3'd0, 7'h20, 0, 0, 0, 0, 2, 0, 0);   // SUB
        run_instr(7'h63, 3'd0, 7'h00, 1, 0, 0, 0, 0, 0, 0);   // BEQ taken
        run_instr(7'h63, 3'd6, 7'h00, 0, 0, 1, 0, 1, 0, 0);   // BLTU not taken
        run_instr(7'h23, 3'd2, 7'h00, 0, 0, 0, 0, 0, 3, 0);   // SW
        run_instr(7'h03, 3'd3, 7'h00, 0, 0, 0, 0, 1, 0, 0);   // LD
        run_instr(7'h67, 3'd0, 7'h00, 0, 0, 0, 0, 0, 0, 0);   // JALR
        run_instr(7'h03, 3'd3, 7'h00, 0, 0, 0, 0, 0, 5, 2);   // LD aborted by reset
        run_instr(7'h7f, 3'd0, 7'h00, 0, 0, 0, 0, 0, 0, 0);   // unknown opcode

        for (int k = 0; k < 200; k++) begin
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : valid_ops[$urandom_range(0, 10)];
            case ($urandom_range(0, 2))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            fl = 4'($urandom);
            run_instr(op, 3'($urandom), f7, fl[0], fl[1], fl[2], fl[3],
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rv64i_control_unit.md
# rv64i_control_unit

Multicycle control unit for the RV64I core. It sequences instruction fetch from instruction memory, decodes `opcode`/`funct3`/`funct7`, and drives every datapath selector. It also evaluates branch conditions from the ALU flags, handshakes with data memory for loads and stores, and pulses `pc_enable` and `write_register_enable` exactly once per retired instruction. It sits between the instruction/data memories and the dataflow block.

## Interface
Parameters: none.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low; forces state IDLE.
- `instruction_mem_enable` out 1: instruction memory read request.
- `instruction_mem_busy` in 1: instruction memory still working.
- `data_mem_enable` out 1: data memory access request.
- `data_mem_byte_write_enable` out 8: byte lanes for stores (all zero for loads).
- `data_mem_busy` in 1: data memory still working.
- `opcode` in 7, `funct3` in 3, `funct7` in 7: current instruction fields.
- `zero`, `negative`, `carry_out`, `overflow` in 1 each: ALU flags.
- `alua_src` out 1: ALU A source; 0 = rs1, 1 = pc (AUIPC).
- `alub_src` out 1: ALU B source; 0 = rs2, 1 = immediate.
- `aluy_src` out 1: result form; 0 = 64-bit result, 1 = sign-extended low 32 bits (W ops).
- `alu_src` out 3: ALU operation, funct3 encoding (000 add/sub … 111 and).
- `carry_in` out 1: ALU carry in; 1 for every subtraction.
- `arithmetic` out 1: 1 = SUB or SRA form.
- `alupc_src` out 1: jump-target base; 0 = pc, 1 = rs1 (JALR).
- `pc_src` out 1: next pc; 0 = pc+4, 1 = target.
- `pc_enable` out 1: PC load strobe.
- `read_data_src` out 3: load extension select; equals load `funct3`.
- `write_register_src` out 2: write-back source; 00 ALU, 01 memory, 10 pc+4, 11 immediate.
- `write_register_enable` out 1: register file write strobe.

## Operation
- States: IDLE, FETCH, FETCH_WAIT, EXECUTE, MEM_WAIT, WRITEBACK.
- Outside EXECUTE, MEM_WAIT and WRITEBACK, every dataflow output, `data_mem_*`, `pc_enable` and `write_register_enable` is 0.
- IDLE → FETCH.
- FETCH: `instruction_mem_enable`=1 for exactly one cycle, then → FETCH_WAIT.
- FETCH_WAIT: hold while `instruction_mem_busy`=1; → EXECUTE when it is 0.
- EXECUTE: drive the decoded selectors combinationally from the current fields.
  - Non-memory instructions: `pc_enable`=1 in this cycle; `write_register_enable`=1 except for branches; then → FETCH.
  - Load/store: `data_mem_enable`=1 for one cycle; stores also drive the byte mask (SB 0x01, SH 0x03, SW 0x0F, SD 0xFF); then → MEM_WAIT.
- MEM_WAIT: selectors held; stay while `data_mem_busy`=1; then → WRITEBACK.
- WRITEBACK: `pc_enable`=1, `write_register_enable`=1 for loads only; then → FETCH.
- Decode per class:
  - OP/OP-32: `alub_src`=0, `alu_src`=funct3, `arithmetic`=funct7[5], `carry_in`=1 for SUB/SLT/SLTU.
  - OP-IMM/OP-IMM-32: `alub_src`=1; `arithmetic`=funct7[5] only for funct3=101.
  - `aluy_src`=1 for the 32-bit opcodes 0011011 and 0111011.
  - LUI: `write_register_src`=11. AUIPC: `alua_src`=1, `alub_src`=1, `alu_src`=000.
  - JAL: `pc_src`=1, `alupc_src`=0, `write_register_src`=10. JALR: same but `alupc_src`=1.
  - Load/store: `alub_src`=1, `alu_src`=000, `arithmetic`=0. Load: `write_register_src`=01, `read_data_src`=funct3.
  - Branch: `alub_src`=0, `alu_src`=000, `arithmetic`=1, `carry_in`=1.
- Branch taken (`pc_src`=1) conditions:
  - BEQ: `zero`; BNE: !`zero`.
  - BLT: `negative`^`overflow`; BGE: its inverse.
  - BLTU: !`carry_out`; BGEU: `carry_out`.
  - funct3 010/011 are never taken.
- Unknown opcode: executes as a NOP (EXECUTE with `pc_enable`=1, `pc_src`=0, no writes).

## Timing
- `reset` low → all outputs 0 immediately, state IDLE; release then takes one IDLE cycle before FETCH.
- `reset` asserted mid-instruction aborts it with no write and no PC update.
- Non-memory instruction: 3 + (FETCH_WAIT cycles) clocks.
- Load/store: 5 + (fetch-wait and mem-wait) clocks minimum.
- `pc_enable` and `write_register_enable` are single-cycle pulses, asserted together, never during fetch.
- Flags are sampled combinationally in the EXECUTE cycle.
- Busy sampled already low in a wait state → leave that state on the next edge.

## Structure
- Shared package holds:
  - opcode constants;
  - state enum;
  - `write_register_src` codes;
  - byte-mask constants.
- One sub-module, `control_decoder`: purely combinational mapping from fields and flags to selectors, byte mask and `pc_src`. The FSM gates its outputs by state.

## Test plan
- Reset low, then release → all outputs 0; first FETCH asserts `instruction_mem_enable`=1 for one cycle.
- ADD then SUB (funct7=0100000) with busy for 2 cycles → EXECUTE: `arithmetic`=0 then 1, `pc_enable`=`write_register_enable`=1 for one cycle each.
- BEQ with `zero`=1 → `pc_src`=1, `write_register_enable`=0.
- BLTU with `carry_out`=1 → `pc_src`=0.
- SW with `data_mem_busy` high 3 cycles → mask 0x0F with `data_mem_enable`; `pc_enable` only after busy falls; no register write.
- LD → `read_data_src`=011, `write_register_src`=01.
- JALR → `alupc_src`=1, `pc_src`=1, `write_register_src`=10.
- Reset pulled low mid MEM_WAIT → returns to IDLE, no strobes.
